// File: rtl/wr_data_packer.sv
// wr_data_packer: packs IN_WIDTH words into OUT_WIDTH beats for the DDR write FIFO.
// Latency: the word that completes a beat shows up on out_valid one edge after it is accepted.
// Backpressure: holds one beat in the output register and one in the accumulator, then drops in_ready.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_data/valid/last/ready     narrow word stream (valid/ready)
//   out_data/be/last/valid/ready wide beat stream; out_be flags lanes carrying real data
//   beat_cnt, frame_cnt          handshake counters, present only when PACKER_BEAT_CNT_EN is defined
module wr_data_packer #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 128,
   localparam int RATIO    = OUT_WIDTH / IN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [RATIO-1:0]     out_be,
   output logic                 out_last,
   output logic                 out_valid,
`ifdef PACKER_BEAT_CNT_EN
   output logic [31:0]          beat_cnt,
   output logic [15:0]          frame_cnt,
`endif
   input  logic                 out_ready
);

   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

   // accumulator stage
   logic [OUT_WIDTH-1:0] r_acc_data;
   logic [RATIO-1:0]     r_acc_be;
   logic [CW-1:0]        r_cnt;
   logic                 r_acc_last;
   logic                 r_acc_done;

   // output stage
   logic [OUT_WIDTH-1:0] r_out_data;
   logic [RATIO-1:0]     r_out_be;
   logic                 r_out_last;
   logic                 r_out_valid;

   logic                 w_move;
   logic                 w_in_ready;
   logic                 w_accept;
   logic [OUT_WIDTH-1:0] w_acc_data_nxt;
   logic [RATIO-1:0]     w_acc_be_nxt;
   logic [CW-1:0]        w_cnt_nxt;
   logic                 w_acc_last_nxt;
   logic                 w_acc_done_nxt;

   always_comb begin
      // A finished accumulator may advance whenever the output slot is empty or being drained.
      w_move     = r_acc_done && (!r_out_valid || out_ready);
      // Accepting is safe whenever the accumulator is still filling or is about to be vacated.
      w_in_ready = !rst && (!r_acc_done || !r_out_valid || out_ready);
      w_accept   = in_valid && w_in_ready;

      // Start from the cleared accumulator on a move so a same-cycle word lands in lane 0.
      w_acc_data_nxt = w_move ? '0 : r_acc_data;
      w_acc_be_nxt   = w_move ? '0 : r_acc_be;
      w_acc_last_nxt = w_move ? 1'b0 : r_acc_last;
      w_acc_done_nxt = w_move ? 1'b0 : r_acc_done;
      w_cnt_nxt      = r_cnt;

      if (w_accept) begin
         w_acc_data_nxt[int'(r_cnt)*IN_WIDTH +: IN_WIDTH] = in_data;
         w_acc_be_nxt[r_cnt] = 1'b1;
         if (r_cnt == LAST_LANE || in_last) begin
            w_acc_done_nxt = 1'b1;
            w_acc_last_nxt = in_last;
            w_cnt_nxt      = '0;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_data <= '0;
         r_acc_be   <= '0;
         r_cnt      <= '0;
         r_acc_last <= 1'b0;
         r_acc_done <= 1'b0;
      end else begin
         r_acc_data <= w_acc_data_nxt;
         r_acc_be   <= w_acc_be_nxt;
         r_cnt      <= w_cnt_nxt;
         r_acc_last <= w_acc_last_nxt;
         r_acc_done <= w_acc_done_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_be    <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_move) begin
         r_out_data  <= r_acc_data;
         r_out_be    <= r_acc_be;
         r_out_last  <= r_acc_last;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef PACKER_BEAT_CNT_EN
   logic        w_hs;
   logic [31:0] r_beat_cnt;
   logic [15:0] r_frame_cnt;

   assign w_hs = r_out_valid && out_ready;

   // Both counters wrap naturally at their width.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt  <= '0;
         r_frame_cnt <= '0;
      end else if (w_hs) begin
         r_beat_cnt <= r_beat_cnt + 32'd1;
         if (r_out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign beat_cnt  = r_beat_cnt;
   assign frame_cnt = r_frame_cnt;
`endif

   assign in_ready  = w_in_ready;
   assign out_data  = r_out_data;
   assign out_be    = r_out_be;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;

endmodule
